// File: rtl/nic_defs.sv
// Shared NIC frame and beat types. NetworkIf and addr_tpl are the existing frame
// definitions; the transmit beat width and beat record sit alongside them.
package nic_defs;

   localparam int NET_PAYLOAD_W = 512;
   localparam int NET_TX_BEAT_W = 128;

   typedef struct packed {
      logic [31:0] dst_ip;
      logic [15:0] dst_port;
      logic [15:0] src_port;
   } addr_tpl;

   typedef struct packed {
      logic                     valid;
      addr_tpl                  addr;
      logic [NET_PAYLOAD_W-1:0] payload;
   } NetworkIf;

   typedef struct packed {
      logic [NET_TX_BEAT_W-1:0] data;
      logic                     sop;
      logic                     eop;
      addr_tpl                  addr;
   } NetTxBeat;

endpackage

// File: rtl/net_frame_fifo.sv
// Synchronous frame FIFO with wrap-bit pointers. Reads are combinational from the
// head slot; a push while full is accepted only when a pop happens at the same edge.
module net_frame_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 576
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign level   = wr_ptr - rd_ptr;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/net_tx_gearbox.sv
// Frame-to-beat transmit gearbox: buffers NetworkIf frames, drops on full, and sends
// each frame LSB beat first. Optional statistics counters under NET_TX_STATS_EN.
//
// state | meaning
// IDLE  | no frame in the shift register; loads the FIFO head when one is present
// SEND  | tx_valid high; beats leave on handshake, next frame loads without a bubble
module net_tx_gearbox
   import nic_defs::*;
#(
   parameter int NIC_ID     = 0,
   parameter int FIFO_DEPTH = 16,
   parameter int PAYLOAD_W  = 512,
   parameter int BEAT_W     = 128
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [$bits(NetworkIf)-1:0]   net_in,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [BEAT_W-1:0]             tx_data,
   output logic                          tx_sop,
   output logic                          tx_eop,
   output logic [$bits(addr_tpl)-1:0]    tx_addr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [31:0]                   drop_cnt,
   output logic [31:0]                   tx_frame_cnt,
   output logic [31:0]                   stall_cnt,
   output logic                          error
);

   localparam int NBEATS = PAYLOAD_W / BEAT_W;
   localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int ADDR_W = $bits(addr_tpl);
   localparam int FW     = ADDR_W + PAYLOAD_W;
   localparam bit CFG_OK = (PAYLOAD_W == NET_PAYLOAD_W) && (PAYLOAD_W % BEAT_W == 0) &&
                           (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
                           (NIC_ID >= 0);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   if (!CFG_OK) begin : g_cfg_check
      $error("net_tx_gearbox[%0d]: bad PAYLOAD_W/BEAT_W/FIFO_DEPTH", NIC_ID);
   end

   NetworkIf          frame_in;
   logic [0:0]        state;
   logic [PAYLOAD_W-1:0] shreg;
   logic [ADDR_W-1:0] addr_q;
   logic [BCW-1:0]    beat_cnt;
   logic [FW-1:0]     head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              hs;
   logic              last_beat;

   assign frame_in  = net_in;
   assign hs        = tx_valid && tx_ready;
   assign last_beat = (beat_cnt == BCW'(NBEATS - 1));
   assign pop       = !fifo_empty && ((state == IDLE) || (hs && last_beat));
   assign push      = frame_in.valid && (!fifo_full || pop);

   net_frame_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   ({frame_in.addr, frame_in.payload[PAYLOAD_W-1:0]}),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         addr_q   <= '0;
         beat_cnt <= '0;
      end else if (state == IDLE) begin
         if (pop) begin
            shreg    <= head[PAYLOAD_W-1:0];
            addr_q   <= head[FW-1 -: ADDR_W];
            beat_cnt <= '0;
            state    <= SEND;
         end
      end else if (hs) begin
         if (!last_beat) begin
            shreg    <= shreg >> BEAT_W;
            beat_cnt <= beat_cnt + 1'b1;
         end else if (pop) begin
            shreg    <= head[PAYLOAD_W-1:0];
            addr_q   <= head[FW-1 -: ADDR_W];
            beat_cnt <= '0;
         end else begin
            state    <= IDLE;
         end
      end
   end

   assign tx_valid = (state == SEND);
   assign tx_data  = shreg[BEAT_W-1:0];
   assign tx_sop   = tx_valid && (beat_cnt == '0);
   assign tx_eop   = tx_valid && last_beat;
   assign tx_addr  = addr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt <= '0;
         error    <= 1'b0;
      end else if (frame_in.valid && !push) begin
         if (drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
         error <= 1'b1;
      end
   end

`ifdef NET_TX_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_frame_cnt <= '0;
         stall_cnt    <= '0;
      end else begin
         if (hs && last_beat && tx_frame_cnt != '1) tx_frame_cnt <= tx_frame_cnt + 32'd1;
         if (tx_valid && !tx_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   assign tx_frame_cnt = '0;
   assign stall_cnt    = '0;
`endif

endmodule
